// File: rtl/seg7_scan_ctrl_if.sv
// Bus between the time counters and the 7-segment scan controller.
// The master side supplies digits and controls; the slave side drives the display.
interface seg7_scan_ctrl_if;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic [3:0]  blink_mask;
  logic [3:0]  digit_bcd;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame_start;

  modport master (
    output digits_in, dp_in, load, lz_en, blink_mask,
    input  digit_bcd, an, dp_n, frame_start
  );

  modport slave (
    input  digits_in, dp_in, load, lz_en, blink_mask,
    output digit_bcd, an, dp_n, frame_start
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode scan controller with tear-free frame commit, leading-zero
// suppression and anti-ghost guard blanking. Optional blinking with `SCAN_BLINK_EN.
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int               CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Digit i (3..1) is suppressed while it and every more significant digit are zero.
  function automatic logic [3:0] lz_blank_f(input logic [15:0] dig);
    logic seen;
    seen       = 1'b0;
    lz_blank_f = 4'b0000;
    for (int i = 3; i >= 1; i--) begin
      seen          = seen | (dig[4*i +: 4] != 4'h0);
      lz_blank_f[i] = ~seen;
    end
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [19:0]      shadow_q, shadow_d;
  logic [19:0]      disp_q, disp_d;
  logic             pending_q, pending_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             dp_n_q, dp_n_d;
  logic             fs_q, fs_d;

  logic             cnt_last_s;
  logic             commit_s;
  logic             blank_s;
  logic [3:0]       lz_s;
  logic [3:0]       blink_s;
  logic [3:0]       nib_s;
  logic [19:0]      in_s;

`ifdef SCAN_BLINK_EN
  localparam int               BLK_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             phase_q, phase_d;

  // Blink half-period timer and per-digit blink blanking.
  always_comb begin
    if (blk_cnt_q == BLK_LAST) begin
      blk_cnt_d = {BLK_W{1'b0}};
      phase_d   = ~phase_q;
    end else begin
      blk_cnt_d = blk_cnt_q + BLK_W'(1);
      phase_d   = phase_q;
    end
    if (phase_q) begin
      blink_s = bus.blink_mask;
    end else begin
      blink_s = 4'b0000;
    end
  end

  // Blink timer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= {BLK_W{1'b0}};
      phase_q   <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
    end
  end
`else
  logic unused_blink_s;
  assign unused_blink_s = ^bus.blink_mask;
  assign blink_s        = 4'b0000;
`endif

  // Scan position, shadow/commit path and next output values.
  always_comb begin
    in_s       = {bus.digits_in, bus.dp_in};
    cnt_last_s = (cnt_q == CNT_LAST);
    commit_s   = (idx_q == 2'd3) && cnt_last_s;

    if (cnt_last_s) begin
      cnt_d = {CNT_W{1'b0}};
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
      idx_d = idx_q;
    end

    if (bus.load) begin
      shadow_d = in_s;
    end else begin
      shadow_d = shadow_q;
    end

    // A load landing on the commit cycle bypasses the shadow so it is never a frame late.
    disp_d    = disp_q;
    pending_d = pending_q;
    if (commit_s) begin
      pending_d = 1'b0;
      if (bus.load) begin
        disp_d = in_s;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end else begin
        disp_d = disp_q;
      end
    end else if (bus.load) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    case (idx_q)
      2'd0:    nib_s = disp_q[7:4];
      2'd1:    nib_s = disp_q[11:8];
      2'd2:    nib_s = disp_q[15:12];
      2'd3:    nib_s = disp_q[19:16];
      default: nib_s = 4'hF;
    endcase

    if (bus.lz_en) begin
      lz_s = lz_blank_f(disp_q[19:4]);
    end else begin
      lz_s = 4'b0000;
    end

    blank_s = (cnt_q < GUARD_C) || lz_s[idx_q] || blink_s[idx_q];
    if (blank_s) begin
      an_d   = 4'b1111;
      bcd_d  = 4'hF;
      dp_n_d = 1'b1;
    end else begin
      an_d   = ~(4'b0001 << idx_q);
      bcd_d  = nib_s;
      dp_n_d = ~disp_q[idx_q];
    end
    fs_d = commit_s;
  end

  // State and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= {CNT_W{1'b0}};
      idx_q     <= 2'd0;
      shadow_q  <= 20'h00000;
      disp_q    <= 20'h00000;
      pending_q <= 1'b0;
      an_q      <= 4'b1111;
      bcd_q     <= 4'hF;
      dp_n_q    <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      bcd_q     <= bcd_d;
      dp_n_q    <= dp_n_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.digit_bcd   = bcd_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed frame checks plus random
// stimulus against a cycle-position reference model.
module tb_seg7_scan_ctrl;
  localparam int R  = 8;
  localparam int G  = 2;
  localparam int BD = 20;
`ifdef SCAN_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  seg7_scan_ctrl_if bus_if();

  seg7_scan_ctrl #(.REFRESH_DIV(R), .GUARD(G), .BLINK_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: position is just the cycle count since reset.
  int          k;
  logic [15:0] m_dig, m_sh_dig;
  logic [3:0]  m_dp, m_sh_dp;
  bit          m_pend;
  logic [3:0]  e_an, e_bcd;
  logic        e_dp, e_fs;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step();
    int  cnt, idx;
    bit  ph, blank;
    if (rst) begin
      k = 0; m_dig = 16'h0; m_dp = 4'h0; m_sh_dig = 16'h0; m_sh_dp = 4'h0; m_pend = 1'b0;
      e_an = 4'hF; e_bcd = 4'hF; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      cnt   = k % R;
      idx   = (k / R) % 4;
      ph    = BLINK_ON && (((k / BD) % 2) == 1);
      blank = (cnt < G) || (bus_if.lz_en && idx > 0 && (m_dig >> (4 * idx)) == 16'h0)
              || (ph && bus_if.blink_mask[idx]);
      e_an  = blank ? 4'hF : ~(4'b0001 << idx);
      e_bcd = blank ? 4'hF : m_dig[4*idx +: 4];
      e_dp  = blank ? 1'b1 : ~m_dp[idx];
      e_fs  = (k % (4 * R)) == (4 * R - 1);
      if (e_fs) begin
        if (bus_if.load) begin
          m_dig = bus_if.digits_in; m_dp = bus_if.dp_in;
        end else if (m_pend) begin
          m_dig = m_sh_dig; m_dp = m_sh_dp;
        end
        m_pend = 1'b0;
      end else if (bus_if.load) begin
        m_pend = 1'b1;
      end
      if (bus_if.load) begin
        m_sh_dig = bus_if.digits_in; m_sh_dp = bus_if.dp_in;
      end
      k++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("an",          16'(bus_if.an),          16'(e_an));
    check("digit_bcd",   16'(bus_if.digit_bcd),   16'(e_bcd));
    check("dp_n",        16'(bus_if.dp_n),        16'(e_dp));
    check("frame_start", 16'(bus_if.frame_start), 16'(e_fs));
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus_if.frame_start !== 1'b1 && n < 40);
    check("frame_start_seen", 16'(bus_if.frame_start), 16'd1);
  endtask

  task automatic run_to(input int idx, input int cnt);
    int n = 0;
    while (!(((k / R) % 4) == idx && (k % R) == cnt) && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] dp);
    bus_if.digits_in = d;
    bus_if.dp_in     = dp;
    bus_if.load      = 1'b1;
    tick();
    bus_if.load      = 1'b0;
  endtask

  // Literal expectations for one whole frame, starting right after frame_start.
  task automatic frame_check(input logic [15:0] nib, input logic [3:0] blank, input logic [3:0] dpr);
    int slot, c;
    logic [3:0] xa, xb;
    logic       xd;
    for (int j = 1; j <= 32; j++) begin
      tick();
      slot = (j - 1) / 8;
      c    = (j - 1) % 8;
      if (c < 2 || blank[slot]) begin
        xa = 4'hF; xb = 4'hF; xd = 1'b1;
      end else begin
        xa = ~(4'b0001 << slot); xb = nib[4*slot +: 4]; xd = ~dpr[slot];
      end
      check("frame_an",  16'(bus_if.an),        16'(xa));
      check("frame_bcd", 16'(bus_if.digit_bcd), 16'(xb));
      check("frame_dp",  16'(bus_if.dp_n),      16'(xd));
    end
  endtask

  initial begin
    int blank01, blank23, slot, c;
    rst = 1'b1;
    bus_if.digits_in = 16'h0; bus_if.dp_in = 4'h0; bus_if.load = 1'b0;
    bus_if.lz_en = 1'b0; bus_if.blink_mask = 4'h0;
    repeat (3) tick();
    check("rst_an",  16'(bus_if.an),        16'hF);
    check("rst_bcd", 16'(bus_if.digit_bcd), 16'hF);
    check("rst_dp",  16'(bus_if.dp_n),      16'h1);
    rst = 1'b0;
    repeat (3) tick();
    check("first_lit_an",  16'(bus_if.an),        16'hE);
    check("first_lit_bcd", 16'(bus_if.digit_bcd), 16'h0);

    // Basic display with one decimal point.
    pulse_load(16'h1234, 4'b0100);
    wait_fs();
    frame_check(16'h1234, 4'b0000, 4'b0100);

    // Mid-frame load must not tear the frame in flight.
    run_to(1, 3);
    pulse_load(16'h5678, 4'b0000);
    run_to(2, 4);
    tick();
    check("tear_an",  16'(bus_if.an),        16'hB);
    check("tear_bcd", 16'(bus_if.digit_bcd), 16'h2);
    wait_fs();
    frame_check(16'h5678, 4'b0000, 4'b0000);

    // Load exactly on the commit cycle.
    bus_if.lz_en = 1'b1;
    run_to(3, 7);
    pulse_load(16'h0009, 4'b0000);
    check("bypass_fs", 16'(bus_if.frame_start), 16'h1);
    frame_check(16'h0009, 4'b1110, 4'b0000);

    // Leading-zero edges.
    pulse_load(16'h0000, 4'b0000);
    wait_fs();
    frame_check(16'h0000, 4'b1110, 4'b0000);
    pulse_load(16'h0100, 4'b0000);
    wait_fs();
    frame_check(16'h0100, 4'b1000, 4'b0000);

    // Reset with a pending load.
    bus_if.lz_en = 1'b0;
    pulse_load(16'h1234, 4'b0000);
    run_to(2, 3);
    rst = 1'b1;
    tick();
    check("midrst_an",  16'(bus_if.an),        16'hF);
    check("midrst_bcd", 16'(bus_if.digit_bcd), 16'hF);
    check("midrst_dp",  16'(bus_if.dp_n),      16'h1);
    rst = 1'b0;
    wait_fs();
    frame_check(16'h0000, 4'b0000, 4'b0000);

    // Blinking of digits 0 and 1.
    bus_if.blink_mask = 4'b0011;
    pulse_load(16'h1234, 4'b0000);
    wait_fs();
    blank01 = 0;
    blank23 = 0;
    for (int j = 1; j <= 80; j++) begin
      tick();
      slot = ((j - 1) / 8) % 4;
      c    = (j - 1) % 8;
      if (c >= 2 && bus_if.an == 4'hF) begin
        if (slot < 2) blank01++;
        else          blank23++;
      end
    end
    check("blink23_none", 16'(blank23), 16'd0);
    check("blink01_seen", 16'(blank01 > 0), 16'(BLINK_ON));

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      logic [15:0] d;
      for (int q = 0; q < 4; q++) begin
        d[4*q +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      rst               = ($urandom_range(0, 199) == 0);
      bus_if.load       = ($urandom_range(0, 5) == 0);
      bus_if.digits_in  = d;
      bus_if.dp_in      = 4'($urandom_range(0, 15));
      bus_if.lz_en      = 1'($urandom_range(0, 1));
      bus_if.blink_mask = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0;
    bus_if.load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
